// File: rtl/branch_target_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer_pkg
// Description : Shared branch-prediction types and constants (BTB + predictor)
// Revision    : 1.0 - initial release
// ============================================================================
package branch_target_buffer_pkg;

    localparam int PC_WIDTH       = 32;
    localparam int PC_SHARE_WIDTH = 8;

    // Prediction payload carried from F through ID to EX
    typedef struct packed {
        logic                v;
        logic [PC_WIDTH-1:0] pc;
        logic                pred;
        logic [PC_WIDTH-1:0] pred_tgt;
    } stage_t;

    localparam stage_t c_stage_idle = '0;

    // Word-aligned PC slice used to index the local predictor
    function automatic logic [PC_SHARE_WIDTH-1:0] pc_share(input logic [PC_WIDTH-1:0] pc);
        return pc[PC_SHARE_WIDTH+1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_buffer_table.sv
`default_nettype none
// ============================================================================
// Module      : btb_table
// Description : Direct-mapped valid/tag/target store, one read + one write port
// Revision    : 1.0 - initial release
// ============================================================================
module btb_table #(
    parameter int IDX_WIDTH  = 6,
    parameter int TAG_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    output logic                  rd_hit,
    output logic [DATA_WIDTH-1:0] rd_tgt,
    input  logic                  wr_en,
    input  logic [IDX_WIDTH-1:0]  wr_idx,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_tgt
);

    localparam int c_depth = 1 << IDX_WIDTH;

    logic [c_depth-1:0]    r_valid;
    logic [TAG_WIDTH-1:0]  r_tag [c_depth];
    logic [DATA_WIDTH-1:0] r_tgt [c_depth];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Payload arrays are gated by the valid bits, so they need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx] <= wr_tag;
            r_tgt[wr_idx] <= wr_tgt;
        end
    end

    assign rd_hit = r_valid[rd_idx] & (r_tag[rd_idx] == rd_tag);
    assign rd_tgt = r_tgt[rd_idx];

endmodule
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : BTB lookup, F->ID->EX prediction pipeline and EX resolution.
//               Define BTB_STATS_EN to add saturating lookup/hit/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int IDX_WIDTH = 6,
    parameter int TAG_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic [PC_WIDTH-1:0]       pc_f,
    input  logic                      predict_taken,
    input  logic                      ex_is_branch,
    input  logic                      ex_taken,
    input  logic [PC_WIDTH-1:0]       ex_target,
    output logic [PC_SHARE_WIDTH-1:0] pc_share_rd,
    output logic [PC_WIDTH-1:0]       next_pc_pred,
    output logic                      pred_taken_f,
    output logic                      enable,
    output logic                      taken,
    output logic [PC_SHARE_WIDTH-1:0] pc_share_wr,
    output logic                      mispredict,
    output logic [PC_WIDTH-1:0]       redirect_pc
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]               stat_lookups,
    output logic [31:0]               stat_hits,
    output logic [31:0]               stat_mispredicts
`endif
);

    stage_t                r_id;
    stage_t                r_ex;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic                  w_hit;
    logic [PC_WIDTH-1:0]   w_rd_tgt;
    logic                  w_br;
    logic                  w_tgt_wrong;

    assign w_idx = pc_f[IDX_WIDTH+1:2];
    assign w_tag = pc_f[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2];

    btb_table #(
        .IDX_WIDTH  (IDX_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (PC_WIDTH)
    ) u_table (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_idx  (w_idx),
        .rd_tag  (w_tag),
        .rd_hit  (w_hit),
        .rd_tgt  (w_rd_tgt),
        .wr_en   (w_br & ex_taken),
        .wr_idx  (r_ex.pc[IDX_WIDTH+1:2]),
        .wr_tag  (r_ex.pc[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2]),
        .wr_tgt  (ex_target)
    );

    assign pc_share_rd  = pc_share(pc_f);
    assign pred_taken_f = w_hit & predict_taken;
    assign next_pc_pred = pred_taken_f ? w_rd_tgt : pc_f + 32'd4;

    // Resolution is suppressed while stalled so each branch updates exactly once
    assign w_br        = r_ex.v & ex_is_branch & ~stall;
    assign w_tgt_wrong = ex_taken & r_ex.pred & (ex_target != r_ex.pred_tgt);
    assign enable      = w_br;
    assign taken       = ex_taken;
    assign pc_share_wr = pc_share(r_ex.pc);
    assign mispredict  = w_br & ((ex_taken != r_ex.pred) | w_tgt_wrong);
    assign redirect_pc = ex_taken ? ex_target : r_ex.pc + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_id <= c_stage_idle;
            r_ex <= c_stage_idle;
        end else if (!stall) begin
            r_id <= '{v: ~mispredict, pc: pc_f, pred: pred_taken_f, pred_tgt: w_rd_tgt};
            r_ex <= '{v: r_id.v & ~mispredict, pc: r_id.pc, pred: r_id.pred,
                      pred_tgt: r_id.pred_tgt};
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_lookups;
    logic [31:0] r_hits;
    logic [31:0] r_mispredicts;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lookups     <= '0;
            r_hits        <= '0;
            r_mispredicts <= '0;
        end else begin
            if (!stall && r_lookups != '1) begin
                r_lookups <= r_lookups + 32'd1;
            end
            if (!stall && w_hit && r_hits != '1) begin
                r_hits <= r_hits + 32'd1;
            end
            if (mispredict && r_mispredicts != '1) begin
                r_mispredicts <= r_mispredicts + 32'd1;
            end
        end
    end

    assign stat_lookups     = r_lookups;
    assign stat_hits        = r_hits;
    assign stat_mispredicts = r_mispredicts;
`else
    // Statistics counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Directed vector bench for branch_target_buffer
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic [31:0] pc_f;
    logic        predict_taken;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [7:0]  pc_share_rd;
    logic [31:0] next_pc_pred;
    logic        pred_taken_f;
    logic        enable;
    logic        taken;
    logic [7:0]  pc_share_wr;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    branch_target_buffer #(.IDX_WIDTH(6), .TAG_WIDTH(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .pc_f          (pc_f),
        .predict_taken (predict_taken),
        .ex_is_branch  (ex_is_branch),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .pc_share_rd   (pc_share_rd),
        .next_pc_pred  (next_pc_pred),
        .pred_taken_f  (pred_taken_f),
        .enable        (enable),
        .taken         (taken),
        .pc_share_wr   (pc_share_wr),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_hits        (stat_hits),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
        logic        e_pred;
        logic [31:0] e_npc;
        logic        e_en;
        logic        e_mis;
        logic [31:0] e_redir;
        logic [7:0]  e_wr;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] pc, input logic pt,
                         input logic br, input logic tk, input logic [31:0] tgt);
        stall         = st;
        pc_f          = pc;
        predict_taken = pt;
        ex_is_branch  = br;
        ex_taken      = tk;
        ex_target     = tgt;
    endtask

    task automatic check_res(input string tag, input logic e_en, input logic e_mis,
                             input logic [31:0] e_redir, input logic [7:0] e_wr);
        chk({tag, " enable"}, {31'd0, enable}, {31'd0, e_en});
        chk({tag, " mispredict"}, {31'd0, mispredict}, {31'd0, e_mis});
        if (e_mis) chk({tag, " redirect_pc"}, redirect_pc, e_redir);
        if (e_en) begin
            chk({tag, " pc_share_wr"}, {24'd0, pc_share_wr}, {24'd0, e_wr});
            chk({tag, " taken"}, {31'd0, taken}, {31'd0, ex_taken});
        end
    endtask

    task automatic check_look(input string tag, input logic e_pred, input logic [31:0] e_npc);
        chk({tag, " pred_taken_f"}, {31'd0, pred_taken_f}, {31'd0, e_pred});
        chk({tag, " next_pc_pred"}, next_pc_pred, e_npc);
    endtask

    initial begin
        //             pc     pt br tk tgt     pred npc    en mis redir  wr
        vecs[0]  = '{32'h100, 1, 0, 0, 32'h0,   0, 32'h104, 0, 0, 32'h0,   8'h00};
        vecs[1]  = '{32'h104, 0, 0, 0, 32'h0,   0, 32'h108, 0, 0, 32'h0,   8'h00};
        vecs[2]  = '{32'h108, 0, 1, 1, 32'h200, 0, 32'h10c, 1, 1, 32'h200, 8'h40};
        vecs[3]  = '{32'h100, 1, 1, 1, 32'h0,   1, 32'h200, 0, 0, 32'h0,   8'h00};
        vecs[4]  = '{32'h200, 0, 0, 0, 32'h0,   0, 32'h204, 0, 0, 32'h0,   8'h00};
        vecs[5]  = '{32'h204, 0, 1, 0, 32'h0,   0, 32'h208, 1, 1, 32'h104, 8'h40};
        vecs[6]  = '{32'h100, 1, 0, 0, 32'h0,   1, 32'h200, 0, 0, 32'h0,   8'h00};
        vecs[7]  = '{32'h200, 1, 0, 0, 32'h0,   0, 32'h204, 0, 0, 32'h0,   8'h00};
        vecs[8]  = '{32'h204, 0, 1, 1, 32'h300, 0, 32'h208, 1, 1, 32'h300, 8'h40};
        vecs[9]  = '{32'h100, 1, 0, 0, 32'h0,   1, 32'h300, 0, 0, 32'h0,   8'h00};
        vecs[10] = '{32'h200, 1, 0, 0, 32'h0,   0, 32'h204, 0, 0, 32'h0,   8'h00};
        vecs[11] = '{32'h204, 0, 1, 1, 32'h300, 0, 32'h208, 1, 0, 32'h0,   8'h40};
        vecs[12] = '{32'h100, 1, 1, 1, 32'h400, 1, 32'h300, 1, 1, 32'h400, 8'h80};
        vecs[13] = '{32'h100, 1, 0, 0, 32'h0,   0, 32'h104, 0, 0, 32'h0,   8'h00};
        vecs[14] = '{32'h200, 1, 0, 0, 32'h0,   1, 32'h400, 0, 0, 32'h0,   8'h00};
        vecs[15] = '{32'h300, 0, 0, 0, 32'h0,   0, 32'h304, 0, 0, 32'h0,   8'h00};

        reset_n = 1'b0;
        drive(0, 32'h100, 1, 1, 1, 32'h0);
        @(posedge clk);
        #4;
        check_look("reset", 0, 32'h104);
        check_res("reset", 0, 0, 32'h0, 8'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // First vector is applied in the cycle right after reset release
        for (int i = 0; i < 16; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            drive(0, vecs[i].pc, vecs[i].pt, vecs[i].br, vecs[i].tk, vecs[i].tgt);
            #3;
            check_look($sformatf("v%0d", i), vecs[i].e_pred, vecs[i].e_npc);
            chk($sformatf("v%0d pc_share_rd", i), {24'd0, pc_share_rd}, {24'd0, vecs[i].pc[9:2]});
            check_res($sformatf("v%0d", i), vecs[i].e_en, vecs[i].e_mis, vecs[i].e_redir,
                      vecs[i].e_wr);
        end

        // EX now holds 0x200 predicted taken to 0x400; stall with a new target pending
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 drive(1, 32'h200, 1, 1, 1, 32'h500);
            #3;
            check_res($sformatf("stall%0d", i), 0, 0, 32'h0, 8'h0);
            check_look($sformatf("stall%0d", i), 1, 32'h400);
        end
        @(posedge clk);
        #1 drive(0, 32'h200, 1, 1, 1, 32'h500);
        #3;
        check_res("release", 1, 1, 32'h500, 8'h80);
        check_look("release", 1, 32'h400);
        @(posedge clk);
        #1 drive(0, 32'h200, 1, 1, 1, 32'h500);
        #3;
        check_res("post_release", 0, 0, 32'h0, 8'h0);
        check_look("post_release", 1, 32'h500);
        @(posedge clk);
        #1 drive(0, 32'h300, 0, 0, 0, 32'h0);

        // EX holds a valid 0x200 branch when reset hits mid-cycle
        @(posedge clk);
        #1 drive(0, 32'h200, 1, 1, 1, 32'h600);
        #1;
        chk("pre_reset enable", {31'd0, enable}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check_res("async_reset", 0, 0, 32'h0, 8'h0);
        check_look("async_reset", 0, 32'h204);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #3;
        check_res("after_reset", 0, 0, 32'h0, 8'h0);
        check_look("after_reset", 0, 32'h204);
        @(posedge clk);
        #4;
        check_look("after_reset2", 0, 32'h204);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
